// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory stage: op codes and
// the widths of the pass-through write-back controls.
package mem_stage_pkg;
  localparam int DM_OP_BIT        = 3;
  localparam int IM_ADDR_BIT      = 32;
  localparam int MUX_RF_DATAW_BIT = 2;

  typedef enum logic [DM_OP_BIT-1:0] {
    DM_WORD  = 3'd0,
    DM_BYTE  = 3'd1,
    DM_BYTEU = 3'd2,
    DM_HALF  = 3'd3,
    DM_HALFU = 3'd4
  } dm_op_e;
endpackage

// File: rtl/mem_stage_dm_ram.sv
// Single-port synchronous data RAM, read-first,
// with per-byte write enables and a clearable read register.
module dm_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic          i_clr,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [2**AW];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en && !i_clr) begin
      for (int k = 0; k < 4; k++) begin
        if (i_be[k])
          r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rdata <= '0;
    else if (i_clr)
      r_rdata <= '0;
    else if (i_en)
      r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage and MEM/WB register: sub-word stores,
// load extraction/extension and misalignment detection.
import mem_stage_pkg::*;

module mem_stage #(
  parameter int DM_ADDR_BIT = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        clear,
  input  logic [IM_ADDR_BIT-1:0]      pc_4_in,
  input  logic [31:0]                 alu_data_res_in,
  input  logic [31:0]                 regfile_data_b_in,
  input  logic [DM_OP_BIT-1:0]        datamem_op_in,
  input  logic                        datamem_w_en_in,
  input  logic                        regfile_w_en_in,
  input  logic [4:0]                  regfile_req_w_in,
  input  logic [MUX_RF_DATAW_BIT-1:0] mux_regfile_data_w_in,
  input  logic                        syscall_en_in,
  output logic [IM_ADDR_BIT-1:0]      pc_4,
  output logic [31:0]                 alu_data_res,
  output logic                        regfile_w_en,
  output logic [4:0]                  regfile_req_w,
  output logic [MUX_RF_DATAW_BIT-1:0] mux_regfile_data_w,
  output logic                        syscall_en,
  output logic [31:0]                 mem_data,
  output logic                        align_err
);
  logic [1:0]  w_off;
  logic        w_is_byte;
  logic        w_is_half;
  logic        w_mis;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  logic [1:0]           r_off;
  logic [DM_OP_BIT-1:0] r_op;

  assign w_off     = alu_data_res_in[1:0];
  assign w_is_byte = (datamem_op_in == DM_BYTE) ||
                     (datamem_op_in == DM_BYTEU);
  assign w_is_half = (datamem_op_in == DM_HALF) ||
                     (datamem_op_in == DM_HALFU);
  assign w_mis     = w_is_half ? w_off[0] :
                     (!w_is_byte && (w_off != 2'b00));

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = regfile_data_b_in;
    unique case (1'b1)
      w_is_byte: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{regfile_data_b_in[7:0]}};
      end
      w_is_half: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{regfile_data_b_in[15:0]}};
      end
      default: ;
    endcase
    if (!datamem_w_en_in || w_mis)
      w_be = 4'b0000;
  end

  dm_ram #(.AW(DM_ADDR_BIT)) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (en),
    .i_clr  (clear),
    .i_be   (w_be),
    .i_addr (alu_data_res_in[DM_ADDR_BIT+1:2]),
    .i_wdata(w_wdata),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      r_off              <= '0;
      r_op               <= '0;
      align_err          <= 1'b0;
      pc_4               <= '0;
      alu_data_res       <= '0;
      regfile_w_en       <= 1'b0;
      regfile_req_w      <= '0;
      mux_regfile_data_w <= '0;
      syscall_en         <= 1'b0;
    end else if (en) begin
      r_off              <= w_off;
      r_op               <= datamem_op_in;
      align_err          <= w_mis;
      pc_4               <= pc_4_in;
      alu_data_res       <= alu_data_res_in;
      regfile_w_en       <= regfile_w_en_in;
      regfile_req_w      <= regfile_req_w_in;
      mux_regfile_data_w <= mux_regfile_data_w_in;
      syscall_en         <= syscall_en_in;
    end
  end

  assign w_byte = w_rdata[{r_off, 3'b000} +: 8];
  assign w_half = w_rdata[{r_off[1], 4'b0000} +: 16];

  always_comb begin
    mem_data = w_rdata;
    case (r_op)
      DM_BYTE:  mem_data = {{24{w_byte[7]}}, w_byte};
      DM_BYTEU: mem_data = {24'd0, w_byte};
      DM_HALF:  mem_data = {{16{w_half[15]}}, w_half};
      DM_HALFU: mem_data = {16'd0, w_half};
      default:  ;
    endcase
    // a misaligned load never returns data
    if (align_err)
      mem_data = '0;
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stores, sub-word loads,
// misalignment, stall, flush, read-during-write and reset.
import mem_stage_pkg::*;

module tb_mem_stage;
  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        en = 1'b1;
  logic                        clear = 1'b0;
  logic [IM_ADDR_BIT-1:0]      pc_4_in = '0;
  logic [31:0]                 alu_data_res_in = '0;
  logic [31:0]                 regfile_data_b_in = '0;
  logic [DM_OP_BIT-1:0]        datamem_op_in = '0;
  logic                        datamem_w_en_in = 1'b0;
  logic                        regfile_w_en_in = 1'b0;
  logic [4:0]                  regfile_req_w_in = '0;
  logic [MUX_RF_DATAW_BIT-1:0] mux_regfile_data_w_in = '0;
  logic                        syscall_en_in = 1'b0;
  logic [IM_ADDR_BIT-1:0]      pc_4;
  logic [31:0]                 alu_data_res;
  logic                        regfile_w_en;
  logic [4:0]                  regfile_req_w;
  logic [MUX_RF_DATAW_BIT-1:0] mux_regfile_data_w;
  logic                        syscall_en;
  logic [31:0]                 mem_data;
  logic                        align_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_stage #(.DM_ADDR_BIT(10)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .en                   (en),
    .clear                (clear),
    .pc_4_in              (pc_4_in),
    .alu_data_res_in      (alu_data_res_in),
    .regfile_data_b_in    (regfile_data_b_in),
    .datamem_op_in        (datamem_op_in),
    .datamem_w_en_in      (datamem_w_en_in),
    .regfile_w_en_in      (regfile_w_en_in),
    .regfile_req_w_in     (regfile_req_w_in),
    .mux_regfile_data_w_in(mux_regfile_data_w_in),
    .syscall_en_in        (syscall_en_in),
    .pc_4                 (pc_4),
    .alu_data_res         (alu_data_res),
    .regfile_w_en         (regfile_w_en),
    .regfile_req_w        (regfile_req_w),
    .mux_regfile_data_w   (mux_regfile_data_w),
    .syscall_en           (syscall_en),
    .mem_data             (mem_data),
    .align_err            (align_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic acc(input dm_op_e op,
                     input logic [31:0] addr,
                     input logic [31:0] data,
                     input logic we,
                     input logic [31:0] pc);
    datamem_op_in     = op;
    alu_data_res_in   = addr;
    regfile_data_b_in = data;
    datamem_w_en_in   = we;
    pc_4_in           = pc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_mem_data", mem_data, 32'h0);
    chk("rst_align", {31'd0, align_err}, 32'h0);
    chk("rst_pc4", pc_4, 32'h0);
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    regfile_w_en_in  = 1'b1;
    regfile_req_w_in = 5'd7;
    syscall_en_in    = 1'b1;
    acc(DM_WORD, 32'h10, 32'hDEADBEEF, 1'b1, 32'h4);
    chk("pass_pc4", pc_4, 32'h4);
    chk("pass_req", {27'd0, regfile_req_w}, 32'd7);
    chk("pass_sys", {31'd0, syscall_en}, 32'd1);
    regfile_w_en_in = 1'b0;
    syscall_en_in   = 1'b0;
    acc(DM_WORD, 32'h10, 32'h0, 1'b0, 32'h8);
    chk("lw_10", mem_data, 32'hDEADBEEF);
    chk("lw_10_align", {31'd0, align_err}, 32'h0);
    chk("pass_alu", alu_data_res, 32'h10);

    acc(DM_WORD, 32'h20, 32'h80FF7F01, 1'b1, 32'h0);
    acc(DM_BYTE, 32'h23, 32'h0, 1'b0, 32'h0);
    chk("lb_23", mem_data, 32'hFFFFFF80);
    acc(DM_BYTEU, 32'h23, 32'h0, 1'b0, 32'h0);
    chk("lbu_23", mem_data, 32'h00000080);
    acc(DM_HALF, 32'h20, 32'h0, 1'b0, 32'h0);
    chk("lh_20", mem_data, 32'h00007F01);
    acc(DM_HALFU, 32'h22, 32'h0, 1'b0, 32'h0);
    chk("lhu_22", mem_data, 32'h000080FF);
    acc(DM_HALF, 32'h22, 32'h0, 1'b0, 32'h0);
    chk("lh_22", mem_data, 32'hFFFF80FF);
    acc(DM_BYTEU, 32'h21, 32'h0, 1'b0, 32'h0);
    chk("lbu_21", mem_data, 32'h0000007F);

    acc(DM_WORD, 32'h30, 32'h0, 1'b1, 32'h0);
    acc(DM_BYTE, 32'h31, 32'hFFFFFFAB, 1'b1, 32'h0);
    acc(DM_HALF, 32'h32, 32'hFFFF1234, 1'b1, 32'h0);
    acc(DM_WORD, 32'h30, 32'h0, 1'b0, 32'h0);
    chk("lanes_30", mem_data, 32'h1234AB00);

    acc(DM_WORD, 32'h40, 32'h11223344, 1'b1, 32'h0);
    acc(DM_WORD, 32'h41, 32'h55, 1'b1, 32'h0);
    chk("sw_mis_err", {31'd0, align_err}, 32'h1);
    chk("sw_mis_data", mem_data, 32'h0);
    acc(DM_WORD, 32'h40, 32'h0, 1'b0, 32'h0);
    chk("lw_40_kept", mem_data, 32'h11223344);
    chk("lw_40_align", {31'd0, align_err}, 32'h0);
    acc(DM_HALF, 32'h43, 32'h0, 1'b0, 32'h0);
    chk("lh_43_data", mem_data, 32'h0);
    chk("lh_43_err", {31'd0, align_err}, 32'h1);

    acc(DM_WORD, 32'h10, 32'h0, 1'b0, 32'h100);
    en = 1'b0;
    acc(DM_WORD, 32'h14, 32'h99, 1'b1, 32'h200);
    chk("stall_data", mem_data, 32'hDEADBEEF);
    chk("stall_pc4", pc_4, 32'h100);
    en = 1'b1;
    acc(DM_WORD, 32'h14, 32'h0, 1'b0, 32'h0);
    acc(DM_WORD, 32'h10, 32'h0, 1'b0, 32'h0);
    chk("stall_nowr", mem_data, 32'hDEADBEEF);

    clear           = 1'b1;
    regfile_w_en_in = 1'b1;
    acc(DM_WORD, 32'h10, 32'h77, 1'b1, 32'h300);
    chk("clr_data", mem_data, 32'h0);
    chk("clr_wen", {31'd0, regfile_w_en}, 32'h0);
    chk("clr_pc4", pc_4, 32'h0);
    chk("clr_alu", alu_data_res, 32'h0);
    clear           = 1'b0;
    regfile_w_en_in = 1'b0;
    acc(DM_WORD, 32'h10, 32'h0, 1'b0, 32'h0);
    chk("clr_nowr", mem_data, 32'hDEADBEEF);

    acc(DM_WORD, 32'h10, 32'h1, 1'b1, 32'h0);
    chk("rdw_old", mem_data, 32'hDEADBEEF);
    acc(DM_WORD, 32'h10, 32'h0, 1'b0, 32'h0);
    chk("rdw_new", mem_data, 32'h1);
    acc(DM_WORD, 32'h1010, 32'h0, 1'b0, 32'h0);
    chk("wrap_1010", mem_data, 32'h1);

    acc(DM_WORD, 32'h10, 32'h0, 1'b0, 32'h44);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_data", mem_data, 32'h0);
    chk("mid_rst_pc4", pc_4, 32'h0);
    chk("mid_rst_alu", alu_data_res, 32'h0);
    #3 rst_n = 1'b1;
    acc(DM_WORD, 32'h10, 32'h0, 1'b0, 32'h0);
    chk("rst_ram_kept", mem_data, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, directly downstream of the EX/MEM stage register (stage 3). Consumes the ALU result as a byte address and the forwarded rt value as store data, performs byte/half/word stores into a synchronous data RAM, and extracts and extends sub-word loads. It also registers all write-back controls, acting as the MEM/WB stage register with the same `en`/`clear` semantics as the other stage registers.

## Interface
- `DM_ADDR_BIT`, default 10: word-address width; RAM depth is 2^DM_ADDR_BIT 32-bit words.
- `clk`  in  1  pipeline clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `en`  in  1  stage enable; 0 = stall (no RAM write, all registers hold).
- `clear`  in  1  synchronous flush; takes priority over `en`.
- `pc_4_in`  in  `IM_ADDR_BIT`  PC+4 of the instruction in MEM.
- `alu_data_res_in`  in  32  ALU result and byte address; RAM index is bits [DM_ADDR_BIT+1:2].
- `regfile_data_b_in`  in  32  store data (rt).
- `datamem_op_in`  in  `DM_OP_BIT`  access size/extension code.
- `datamem_w_en_in`  in  1  store request.
- `regfile_w_en_in`, `regfile_req_w_in[4:0]`, `mux_regfile_data_w_in[MUX_RF_DATAW_BIT-1:0]`, `syscall_en_in`  in  write-back controls, registered through.
- `pc_4`, `alu_data_res`, `regfile_w_en`, `regfile_req_w`, `mux_regfile_data_w`, `syscall_en`  out  registered copies of the inputs above.
- `mem_data`  out  32  extracted, extended load result for the registered instruction.
- `align_err`  out  1  registered; high for the instruction that made a misaligned access.

## Operation
- DM op codes: WORD=0, BYTE=1 (sign-ext), BYTEU=2, HALF=3 (sign-ext), HALFU=4. Other codes behave as WORD.
- Misaligned access: HALF/HALFU with addr[0]=1, or WORD with addr[1:0]≠0.
- Store with `en`=1, `clear`=0, `datamem_w_en_in`=1, and an aligned access:
  - Byte-enabled write.
  - BYTE/BYTEU write rt[7:0] to lane addr[1:0].
  - HALF/HALFU write rt[15:0] to lanes {addr[1],0}/{addr[1],1}.
  - WORD writes all four lanes.
  - Lane k holds bits [8k+7:8k] (little-endian).
- Misaligned store: write suppressed; `align_err` set.
- Read: every enabled cycle, the RAM reads the addressed word into a read register (read-first; a same-cycle store to the same word returns the old word). Address offset [1:0] and op are registered alongside.
- `mem_data` is a combinational extraction from the read register using the registered offset/op. A misaligned load yields 0 plus `align_err`.
- `en`=0: RAM untouched; read register, offset, op and all outputs hold.
- `clear`=1: store suppressed regardless of `en`; all outputs and the read register go to 0 next edge.
- Reset: all outputs, the read register and the offset/op registers go to 0 asynchronously. RAM contents are not reset. During and after reset, `mem_data`=0.

## Timing
- Inputs are sampled at edge N. Registered outputs and `mem_data` are valid after edge N and are consumed by write-back before edge N+1.
- Latency 1 cycle for every output; throughput one access per cycle; no internal stall source.
- A store at edge N is visible to a load sampled at edge N+1 or later; it is not visible at edge N.
- `clear` and `en` asserted together: clear wins.
- `rst_n` deasserting mid-cycle: the first update is at the next rising edge.
- Address bits above DM_ADDR_BIT+1 are ignored (wrap-around).

## Structure
- Shared package/header `Core.vh`: `DM_OP_BIT`, DM op code constants, `IM_ADDR_BIT`, `MUX_RF_DATAW_BIT`.
- Sub-module `dm_ram`: synchronous read-first single-port RAM with 4-bit byte enable, parameterised by DM_ADDR_BIT.
- Byte-enable generation, store-lane replication and load extraction stay in `mem_stage`.

## Test plan
- Word store/load: SW 0xDEADBEEF to 0x10, then LW 0x10 -> `mem_data`=0xDEADBEEF, `align_err`=0.
- Sub-word extension: word 0x80FF7F01 at 0x20:
  - LB 0x23 -> 0xFFFFFF80
  - LBU 0x23 -> 0x00000080
  - LH 0x20 -> 0x00007F01
  - LHU 0x22 -> 0x000080FF
  - LH 0x22 -> 0xFFFF80FF
- Byte-lane stores: SW 0 to 0x30, SB 0xAB to 0x31, SH 0x1234 to 0x32 -> LW 0x30 = 0x1234AB00.
- Misalignment: SW 0x55 to 0x41 -> no write (LW 0x40 unchanged), `align_err`=1 for one cycle; LH 0x43 -> `mem_data`=0, `align_err`=1.
- Stall/flush:
  - `en`=0 with SW pending -> RAM unchanged, outputs hold.
  - `clear`=1 with SW and `regfile_w_en_in`=1 -> no write, all outputs 0 next cycle.
- Read-during-write and reset:
  - SW 0x1 and LW to the same word on the same edge -> old value returned.
  - `rst_n` pulsed low mid-cycle -> all outputs 0 immediately; RAM retains data.
